// File: rtl/apb3_timer_pkg.sv
// Shared definitions for the APB3 timer: register offsets, CTRL bit positions,
// APB slave FSM states and the PERIOD reset value.
package apb3_timer_pkg;

  localparam logic [4:0] CTRL_OFS     = 5'h00;
  localparam logic [4:0] PRESCALE_OFS = 5'h04;
  localparam logic [4:0] PERIOD_OFS   = 5'h08;
  localparam logic [4:0] COUNT_OFS    = 5'h0C;
  localparam logic [4:0] STATUS_OFS   = 5'h10;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_ONESHOT = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;
  localparam int unsigned CTRL_CLR     = 3;

  localparam logic [31:0] PERIOD_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb3_timer_if.sv
// APB3 bus bundle between the SoC master and the timer slave.
interface apb3_timer_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic                  PREADY;
  logic [31:0]           PRDATA;
  logic                  PSLVERROR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERROR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERROR
  );
endinterface

// File: rtl/apb3_timer_core.sv
// Prescaler, 32-bit period counter and PENDING flag; expire pulses on the cycle
// the counter wraps, CLR beats a same-cycle tick and an expiry beats a same-cycle W1C.
module apb3_timer_core
  import apb3_timer_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  w1c,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [31:0]           period,
  output logic [31:0]           count,
  output logic                  pending,
  output logic                  expire
);

  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [31:0]           count_q, count_d;
  logic                  pending_q, pending_d;
  logic                  tick;

  // >= rather than == so shrinking PRESCALE/PERIOD mid-run never wraps the full range
  assign tick   = en && !clr && (psc_q >= prescale);
  assign expire = tick && (count_q >= period);

  always_comb begin
    psc_d     = psc_q;
    count_d   = count_q;
    pending_d = pending_q;

    if (clr || !en || tick) begin
      psc_d = '0;
    end else begin
      psc_d = psc_q + PRESCALE_W'(1);
    end

    if (clr || expire) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + 32'd1;
    end

    if (expire) begin
      pending_d = 1'b1;
    end else if (w1c) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q     <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      psc_q     <= psc_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign count   = count_q;
  assign pending = pending_q;

endmodule

// File: rtl/apb3_timer.sv
// APB3 timer slave: 3-cycle transfers (setup, one wait, ready), back-to-back capable, level irq.
// APB3_TIMER_PSLVERR_EN enables PSLVERROR on unmapped offsets and COUNT writes.
module apb3_timer
  import apb3_timer_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int PRESCALE_W = 16
) (
  input  logic        io_systemClk,
  input  logic        io_systemReset,
  apb3_timer_if.slave apb,
  output logic        irq
);

  apb_state_e            state_q, state_d;
  logic                  pready_q, pready_d;
  logic [31:0]           prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;
  logic                  en_q, en_d;
  logic                  oneshot_q, oneshot_d;
  logic                  irq_en_q, irq_en_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [31:0]           period_q, period_d;
  logic                  irq_q, irq_d;

  logic [4:0]  ofs;
  logic        wr_commit, clr, w1c, bad_access;
  logic [31:0] rd_dat;
  logic [31:0] count;
  logic        pending, expire;
  logic        unused_addr_bits;

  assign ofs              = {apb.PADDR[4:2], 2'b00};
  assign unused_addr_bits = ^{apb.PADDR[ADDR_WIDTH-1:5], apb.PADDR[1:0]};
  assign wr_commit        = (state_q == READY) && apb.PWRITE;
  assign clr              = wr_commit && (ofs == CTRL_OFS) && apb.PWDATA[CTRL_CLR];
  assign w1c              = wr_commit && (ofs == STATUS_OFS) && apb.PWDATA[0];

`ifdef APB3_TIMER_PSLVERR_EN
  assign bad_access = (ofs > STATUS_OFS) || (apb.PWRITE && (ofs == COUNT_OFS));
`else
  assign bad_access = 1'b0;
`endif

  always_comb begin
    rd_dat = '0;
    case (ofs)
      CTRL_OFS:     rd_dat = {29'd0, irq_en_q, oneshot_q, en_q};
      PRESCALE_OFS: rd_dat = 32'(prescale_q);
      PERIOD_OFS:   rd_dat = period_q;
      COUNT_OFS:    rd_dat = count;
      STATUS_OFS:   rd_dat = {31'd0, pending};
      default:      rd_dat = '0;
    endcase
  end

  // Response is captured in WAIT so PRDATA/PSLVERROR are stable for the whole READY cycle
  always_comb begin
    state_d   = state_q;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    case (state_q)
      IDLE: if (apb.PSEL && !apb.PENABLE) state_d = WAIT;
      WAIT: begin
        if (!apb.PSEL) begin
          state_d = IDLE;
        end else begin
          state_d   = READY;
          pready_d  = 1'b1;
          prdata_d  = apb.PWRITE ? 32'd0 : rd_dat;
          pslverr_d = bad_access;
        end
      end
      READY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    en_d       = en_q;
    oneshot_d  = oneshot_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    period_d   = period_q;
    irq_d      = pending && irq_en_q;

    if (wr_commit && (ofs == CTRL_OFS)) begin
      en_d      = apb.PWDATA[CTRL_EN];
      oneshot_d = apb.PWDATA[CTRL_ONESHOT];
      irq_en_d  = apb.PWDATA[CTRL_IRQ_EN];
    end else if (expire && oneshot_q) begin
      en_d = 1'b0;
    end
    if (wr_commit && (ofs == PRESCALE_OFS)) prescale_d = apb.PWDATA[PRESCALE_W-1:0];
    if (wr_commit && (ofs == PERIOD_OFS))   period_d   = apb.PWDATA;
  end

  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      state_q    <= IDLE;
      pready_q   <= 1'b0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      en_q       <= 1'b0;
      oneshot_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= '0;
      period_q   <= PERIOD_RST;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pready_q   <= pready_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
      en_q       <= en_d;
      oneshot_q  <= oneshot_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      period_q   <= period_d;
      irq_q      <= irq_d;
    end
  end

  apb3_timer_core #(.PRESCALE_W(PRESCALE_W)) u_core (
    .clk     (io_systemClk),
    .rst     (io_systemReset),
    .en      (en_q),
    .clr     (clr),
    .w1c     (w1c),
    .prescale(prescale_q),
    .period  (period_q),
    .count   (count),
    .pending (pending),
    .expire  (expire)
  );

  assign apb.PREADY    = pready_q;
  assign apb.PRDATA    = prdata_q;
  assign apb.PSLVERROR = pslverr_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_apb3_timer.sv
// Directed bench for apb3_timer: bus transfers checked against a register-level timer model,
// irq compared against the model every cycle, plus hand-computed literal expectations.
module tb_apb3_timer;

`ifdef APB3_TIMER_PSLVERR_EN
  localparam bit PSLV_ON = 1'b1;
`else
  localparam bit PSLV_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;

  apb3_timer_if #(.ADDR_WIDTH(16)) bus ();

  apb3_timer #(.ADDR_WIDTH(16), .PRESCALE_W(16)) dut (
    .io_systemClk  (clk),
    .io_systemReset(rst),
    .apb           (bus),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Register-level model of the timer
  bit          m_en = 0, m_one = 0, m_ien = 0, m_pend = 0, m_irq = 0;
  int unsigned m_presc = 0, m_phase = 0;
  logic [31:0] m_period = 32'hFFFF_FFFF, m_count = 0;
  int          cmt_seq = 0, seen_seq = 0;
  logic [2:0]  cmt_idx = 0;
  logic [31:0] cmt_dat = 0;

  always @(posedge clk) begin : model
    bit do_wr, clr, w1c, tick, expire;
    do_wr    = (cmt_seq != seen_seq);
    seen_seq = cmt_seq;
    if (rst) begin
      m_en = 0; m_one = 0; m_ien = 0; m_pend = 0; m_irq = 0;
      m_presc = 0; m_phase = 0; m_period = 32'hFFFF_FFFF; m_count = 0;
    end else begin
      m_irq  = m_pend & m_ien;
      clr    = do_wr && cmt_idx == 3'd0 && cmt_dat[3];
      w1c    = do_wr && cmt_idx == 3'd4 && cmt_dat[0];
      tick   = 0;
      if (m_en && !clr) begin
        if (m_phase >= m_presc) begin m_phase = 0; tick = 1; end
        else m_phase = m_phase + 1;
      end else begin
        m_phase = 0;
      end
      expire = tick && (m_count >= m_period);
      if (clr || expire) m_count = 0;
      else if (tick)     m_count = m_count + 1;
      if (expire)        m_pend = 1;
      else if (w1c)      m_pend = 0;
      if (do_wr && cmt_idx == 3'd0) {m_ien, m_one, m_en} = cmt_dat[2:0];
      else if (expire && m_one)     m_en = 0;
      if (do_wr && cmt_idx == 3'd1) m_presc = {16'd0, cmt_dat[15:0]};
      if (do_wr && cmt_idx == 3'd2) m_period = cmt_dat;
    end
  end

  function automatic logic [31:0] mdl_rd(input logic [2:0] idx);
    case (idx)
      3'd0:    return {29'd0, m_ien, m_one, m_en};
      3'd1:    return 32'(m_presc);
      3'd2:    return m_period;
      3'd3:    return m_count;
      3'd4:    return {31'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) check("irq_model", 32'(irq), 32'(m_irq));

  task automatic xfer(input bit wr, input logic [15:0] addr, input logic [31:0] wdat,
                      output logic [31:0] rdat, output logic err);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [2:0]  idx;
    idx = addr[4:2];
    @(negedge clk);
    check("pready_setup", 32'(bus.PREADY), 32'd0);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = addr; bus.PWRITE = wr; bus.PWDATA = wdat;
    @(negedge clk);
    check("pready_wait", 32'(bus.PREADY), 32'd0);
    exp_rd  = wr ? 32'd0 : mdl_rd(idx);
    exp_err = PSLV_ON && ((idx > 3'd4) || (wr && idx == 3'd3));
    bus.PENABLE = 1'b1;
    @(negedge clk);
    check("pready_ready", 32'(bus.PREADY), 32'd1);
    check("prdata", bus.PRDATA, exp_rd);
    check("pslverror", 32'(bus.PSLVERROR), 32'(exp_err));
    rdat = bus.PRDATA;
    err  = bus.PSLVERROR;
    if (wr) begin
      cmt_idx = idx;
      cmt_dat = wdat;
      cmt_seq++;
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_irq(input int limit, output int clks);
    clks = -1;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      #1;
      if (irq) begin
        clks = c - 1;
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          dly;
    int          t1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("irq_reset", 32'(irq), 32'd0);

    xfer(0, 16'h0000, 0, rd, er); check("rst_ctrl", rd, 32'h0);
    xfer(0, 16'h0004, 0, rd, er); check("rst_prescale", rd, 32'h0);
    xfer(0, 16'h0008, 0, rd, er); check("rst_period", rd, 32'hFFFF_FFFF);
    xfer(0, 16'h000C, 0, rd, er); check("rst_count", rd, 32'h0);
    xfer(0, 16'h0010, 0, rd, er); check("rst_status", rd, 32'h0);

    // Reset during the wait state of a PRESCALE write
    idle(1);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = 16'h0004; bus.PWRITE = 1'b1; bus.PWDATA = 32'h55;
    @(negedge clk);
    bus.PENABLE = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("pready_after_rst", 32'(bus.PREADY), 32'd0);
    rst = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    xfer(0, 16'h0004, 0, rd, er); check("rst_write_lost", rd, 32'h0);

    // Periodic: PRESCALE=3, PERIOD=9
    xfer(1, 16'h0004, 3, rd, er);
    xfer(1, 16'h0008, 9, rd, er);
    xfer(1, 16'h0000, 32'h5, rd, er);
    wait_irq(100, dly); check("first_expiry_clks", 32'(dly), 32'd41);
    t1 = cyc;
    xfer(1, 16'h0010, 1, rd, er);
    idle(3); check("irq_cleared", 32'(irq), 32'd0);
    wait_irq(100, dly); check("repeat_period", 32'(cyc - t1), 32'd40);
    xfer(1, 16'h0000, 32'h8, rd, er);
    xfer(1, 16'h0010, 1, rd, er);
    idle(3); check("irq_off", 32'(irq), 32'd0);

    // One-shot: PRESCALE=0, PERIOD=4
    xfer(1, 16'h0004, 0, rd, er);
    xfer(1, 16'h0008, 4, rd, er);
    xfer(1, 16'h0000, 32'h7, rd, er);
    wait_irq(50, dly); check("oneshot_irq_clks", 32'(dly), 32'd6);
    idle(20);
    xfer(0, 16'h0000, 0, rd, er); check("oneshot_ctrl", rd, 32'h6);
    xfer(0, 16'h000C, 0, rd, er); check("oneshot_count", rd, 32'h0);
    xfer(0, 16'h0010, 0, rd, er); check("oneshot_pending", rd, 32'h1);
    xfer(1, 16'h0010, 1, rd, er);
    idle(20);
    xfer(0, 16'h0010, 0, rd, er); check("oneshot_no_rerun", rd, 32'h0);

    // W1C commits on the same edge as a one-shot expiry
    xfer(1, 16'h0000, 0, rd, er);
    xfer(1, 16'h0008, 2, rd, er);
    xfer(1, 16'h0000, 32'hB, rd, er);
    xfer(1, 16'h0010, 1, rd, er);
    xfer(0, 16'h0010, 0, rd, er); check("w1c_vs_expiry", rd, 32'h1);
    xfer(0, 16'h0000, 0, rd, er); check("w1c_ctrl", rd, 32'h2);

    // Lowering PERIOD below COUNT while running
    xfer(1, 16'h0010, 1, rd, er);
    xfer(1, 16'h0008, 100, rd, er);
    xfer(1, 16'h0000, 32'h9, rd, er);
    idle(49);
    xfer(0, 16'h000C, 0, rd, er); check("count_50", rd, 32'd50);
    xfer(1, 16'h0008, 10, rd, er);
    xfer(0, 16'h000C, 0, rd, er); check("period_lowered", rd, 32'd0);
    xfer(1, 16'h0000, 32'h8, rd, er);
    xfer(0, 16'h000C, 0, rd, er); check("clr_count", rd, 32'd0);

    // Unmapped and read-only accesses
    xfer(0, 16'h0018, 0, rd, er);
    check("unmapped_rd_dat", rd, 32'd0);
    check("unmapped_rd_err", 32'(er), 32'(PSLV_ON));
    xfer(1, 16'h000C, 32'h1234, rd, er);
    check("count_wr_dat", rd, 32'd0);
    check("count_wr_err", 32'(er), 32'(PSLV_ON));
    xfer(1, 16'h0014, 32'hFFFF, rd, er);
    xfer(0, 16'h000C, 0, rd, er); check("count_wr_ignored", rd, 32'd0);
    xfer(0, 16'hFF08, 0, rd, er); check("addr_upper_ignored", rd, 32'd10);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/apb3_timer.md
# apb3_timer

APB3 slave periodic/one-shot timer that drives the SoC's user interrupt line. It sits on the SoC's APB slave port 0 (16-bit address space) and feeds `userInterruptA`. Firmware programs a prescaler and a period, and receives a level interrupt on each period expiry until it clears the pending flag.

## Interface
- `ADDR_WIDTH`, 16: APB address width. Only `PADDR[4:2]` is decoded; upper and lower bits are ignored.
- `PRESCALE_W`, 16: prescaler width.

Ports (one clock; reset is synchronous and active-high):
- `io_systemClk`  in  1  system clock
- `io_systemReset`  in  1  synchronous active-high reset
- `PADDR`  in  ADDR_WIDTH  APB address
- `PSEL`  in  1  APB select
- `PENABLE`  in  1  APB enable
- `PWRITE`  in  1  1 = write
- `PWDATA`  in  32  write data
- `PREADY`  out  1  transfer complete, registered
- `PRDATA`  out  32  read data, registered, valid while `PREADY`=1
- `PSLVERROR`  out  1  error response, registered, valid while `PREADY`=1
- `irq`  out  1  level interrupt, registered, equals `PENDING & IRQ_EN`

## Operation
Register map (byte offsets; word index is `PADDR[4:2]`):
- 0x00 `CTRL`, RW, reset 0:
  - bit0 `EN`
  - bit1 `ONESHOT`
  - bit2 `IRQ_EN`
  - bit3 `CLR`: write-only, self-clearing, reads 0.
- 0x04 `PRESCALE`, RW, reset 0: one tick every `PRESCALE+1` clocks.
- 0x08 `PERIOD`, RW, reset 0xFFFF_FFFF.
- 0x0C `COUNT`, RO, reset 0. Writes are ignored.
- 0x10 `STATUS`: bit0 `PENDING`. Write 1 clears it; write 0 has no effect.
- 0x14–0x1C: unmapped. Reads return 0; writes are ignored.

Counter behaviour:
- When `EN`=1, the prescaler counts from 0 up to `PRESCALE`, then wraps to 0 and emits a one-cycle tick.
- On each tick:
  - If `COUNT >= PERIOD`: `COUNT` goes to 0, `PENDING` is set, and `EN` is cleared if `ONESHOT`=1.
  - Otherwise `COUNT` increments by 1.
- The comparison is `>=`. Lowering `PERIOD` below the current `COUNT` therefore expires on the next tick instead of wrapping through 2^32.
- When `EN`=0, `COUNT` holds its value and the prescaler is held at 0.
- Writing `CLR`=1 zeroes `COUNT` and the prescaler in the same write cycle. This takes priority over any tick in that cycle.
- Setting `EN` from 0 to 1 does not reset `COUNT`.
- If an expiry and a `STATUS` W1C happen in the same cycle, the set wins and `PENDING` stays 1.
- A `CTRL` write and a one-shot auto-clear in the same cycle: the written `EN` value wins.

APB slave state machine:
- `IDLE`: `PREADY`=0. On `PSEL & ~PENABLE` (setup phase), go to `WAIT`.
- `WAIT`: this is the first access-phase cycle. `PREADY`=0. Register the read data and the error flag, then go to `READY`.
- `READY`: `PREADY`=1. Writes commit on this clock edge. Then go to `IDLE`.
- If `PSEL` drops in `WAIT` (protocol violation), return to `IDLE` without committing the write.

## Timing
- Reset values: `PREADY`=0, `PRDATA`=0, `PSLVERROR`=0, `irq`=0; all registers take the reset values listed above.
- Each transfer takes 3 cycles: setup, 1 wait state, ready. Back-to-back transfers are accepted with no idle cycle.
- A write becomes visible in the register the cycle after `READY`.
- `irq` rises 1 cycle after `PENDING` is set.
- First expiry after enable: `(PERIOD+1)*(PRESCALE+1)` clocks after the `CTRL` write commits, starting from `COUNT`=0.
- Reset asserted mid-transfer: the FSM returns to `IDLE`, the write is lost, and `PREADY` is 0 on the next cycle.

## Configuration
- `APB3_TIMER_PSLVERR_EN` defined: accesses to an unmapped offset, and writes to `COUNT`, return `PSLVERROR`=1 in `READY`.
- Undefined: `PSLVERROR` is tied to 0, and these accesses complete silently.

## Structure
- Shared package `apb3_timer_pkg`:
  - Register offset constants (`CTRL_OFS` … `STATUS_OFS`)
  - `CTRL` bit indices
  - APB FSM state enum (`IDLE`, `WAIT`, `READY`)
  - `PERIOD` reset constant
- One sub-module, `apb3_timer_core`: prescaler, counter, compare and `PENDING` logic. The top level keeps the APB FSM and register file.

## Test plan
- Reset, then read all offsets: `CTRL`=0, `PRESCALE`=0, `PERIOD`=0xFFFF_FFFF, `COUNT`=0, `STATUS`=0; `irq`=0. Every transfer shows `PREADY` high on exactly the third cycle.
- `PRESCALE`=3, `PERIOD`=9, `CTRL`=0x5: `irq` rises 40 clocks after the commit, plus 1 cycle of registration, and repeats every 40 clocks. Write 1 to `STATUS`: `irq` falls.
- `ONESHOT`: `CTRL`=0x7 with `PERIOD`=4 and `PRESCALE`=0: a single expiry after 5 clocks, after which `CTRL` reads 0x6 and `COUNT` holds at 0.
- Schedule the W1C of `STATUS` to commit on the same edge as an expiry: `PENDING` remains 1.
- While running with `COUNT`=50, write `PERIOD`=10: expiry on the next tick. Write `CTRL.CLR`: `COUNT` reads 0.
- Read offset 0x18 and write `COUNT`: `PSLVERROR`=1 with the macro defined, 0 without; `PRDATA`=0 in both cases.
